// File: rtl/status_flag_writer_pkg.sv
// Shared NZCV definitions for the status-flag producer and the ID-stage
// condition checker: flag bit positions, register width and condition codes.
package status_flag_writer_pkg;

    localparam int unsigned STATUS_W = 4;

    // Bit positions inside the status register.
    localparam int unsigned FLG_N = 0;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_Z = 3;

    // Condition codes evaluated by the condition checker.
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    // Assemble individual flags into the shared register layout.
    function automatic logic [STATUS_W-1:0] pack_flags(input logic n, input logic z,
                                                       input logic c, input logic v);
        logic [STATUS_W-1:0] f;
        f        = '0;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/status_flag_writer_flag_gen.sv
// Combinational NZCV generation from an EXE-stage ALU result.
// Logical/move instructions keep the previous V flag.
module flag_gen
    import status_flag_writer_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_carry,
    input  logic                alu_overflow,
    input  logic                exe_logic,
    input  logic                old_v,
    output logic [STATUS_W-1:0] flags
);

    // Derive the four candidate flags for this result.
    always_comb begin
        flags = pack_flags(alu_result[DATA_W-1],
                           ~|alu_result,
                           alu_carry,
                           exe_logic ? old_v : alu_overflow);
    end

endmodule

// File: rtl/status_flag_writer.sv
// NZCV status register producer: commits EXE-stage flags, tracks in-flight
// flag-setting instructions for the hazard unit.
// Optional macro STATUS_BYPASS_EN forwards committing flags to ID in the
// commit cycle and drops the pending indication one cycle earlier.
module status_flag_writer
    import status_flag_writer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_issue_s,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic              exe_logic,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              flush,
    input  logic              stall,
    output logic [3:0]        status,
    output logic [3:0]        status_fwd,
    output logic              flags_pending,
    output logic              pend_err
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic                commit;
    logic [3:0]          flags_new;
    logic [PEND_W-1:0]   cnt;

    assign commit = exe_valid & exe_s & ~stall;

    flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .exe_logic    (exe_logic),
        .old_v        (status[FLG_V]),
        .flags        (flags_new)
    );

    // Architectural status register; a flush never cancels the EXE commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else if (commit) begin
            status <= flags_new;
        end
    end

    // In-flight flag-writer counter with saturation and sticky error.
    // Flush clears everything younger than EXE; the EXE commit retires its own entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pend_err <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (!stall) begin
            if (id_issue_s && !commit) begin
                if (cnt == CNT_MAX) begin
                    pend_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (commit && !id_issue_s) begin
                if (cnt == '0) begin
                    pend_err <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

`ifdef STATUS_BYPASS_EN
    // Forward the committing flags to ID and discount the committing writer.
    always_comb begin
        status_fwd    = commit ? flags_new : status;
        flags_pending = ((cnt - PEND_W'(commit)) != '0);
    end
`else
    // Registered view only; ID waits until the commit is visible in status.
    always_comb begin
        status_fwd    = status;
        flags_pending = (cnt != '0);
    end
`endif

endmodule

// File: tb/tb_status_flag_writer.sv
module tb_status_flag_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_issue_s;
    logic        exe_valid;
    logic        exe_s;
    logic        exe_logic;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        flush;
    logic        stall;
    logic [3:0]  status;
    logic [3:0]  status_fwd;
    logic        flags_pending;
    logic        pend_err;

    int passed = 0;
    int total  = 0;

    status_flag_writer #(
        .DATA_W (32),
        .PEND_W (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_issue_s    (id_issue_s),
        .exe_valid     (exe_valid),
        .exe_s         (exe_s),
        .exe_logic     (exe_logic),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .flush         (flush),
        .stall         (stall),
        .status        (status),
        .status_fwd    (status_fwd),
        .flags_pending (flags_pending),
        .pend_err      (pend_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic        ev;
        logic        es;
        logic        el;
        logic        st;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic [3:0]  exp;   // status after the edge, bits {Z,C,V,N}
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic iss, input logic ev, input logic es, input logic el,
                         input logic st, input logic fl, input logic [31:0] res,
                         input logic c, input logic v);
        id_issue_s   = iss;
        exe_valid    = ev;
        exe_s        = es;
        exe_logic    = el;
        stall        = st;
        flush        = fl;
        alu_result   = res;
        alu_carry    = c;
        alu_overflow = v;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, sample registered outputs #1 after posedge.
    task automatic cycle(input logic iss, input logic ev, input logic es, input logic el,
                         input logic st, input logic fl, input logic [31:0] res,
                         input logic c, input logic v);
        @(negedge clk);
        drive(iss, ev, es, el, st, fl, res, c, v);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev;
    logic       cm;
    logic [3:0] exp_fwd;

    initial begin
        //          iss ev es el st  res            c  v   exp
        vec[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'b1100};
        vec[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4'b0011};
        vec[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 4'b0010};
        vec[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'b0010};
        vec[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 4'b0010};
        vec[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4'b0010};
        vec[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b0111};
        vec[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 4'b1010};
        vec[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 4'b0110};
        vec[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 4'b0000};

        idle();
        rst_n = 1'b0;
        #1;
        check("reset_status", {28'h0, status}, 32'h0);
        check("reset_pending", {31'h0, flags_pending}, 32'h0);
        check("reset_err", {31'h0, pend_err}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Flag generation / commit table; issue paired with commit keeps cnt at 0.
        prev = 4'b0000;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i].iss, vec[i].ev, vec[i].es, vec[i].el, vec[i].st, 1'b0,
                  vec[i].res, vec[i].c, vec[i].v);
            #1;
            cm = vec[i].ev & vec[i].es & ~vec[i].st;
`ifdef STATUS_BYPASS_EN
            exp_fwd = cm ? vec[i].exp : prev;
`else
            exp_fwd = prev;
`endif
            check($sformatf("vec%0d_fwd", i), {28'h0, status_fwd}, {28'h0, exp_fwd});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_status", i), {28'h0, status}, {28'h0, vec[i].exp});
            check($sformatf("vec%0d_pending", i), {31'h0, flags_pending}, 32'h0);
            check($sformatf("vec%0d_err", i), {31'h0, pend_err}, 32'h0);
            prev = vec[i].exp;
        end

        // Pending sequence: issue, issue, commit, commit.
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("pend_cnt1", {31'h0, flags_pending}, 32'h1);
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("pend_cnt2", {31'h0, flags_pending}, 32'h1);
        cycle(0, 1, 1, 0, 0, 0, 32'h0, 1, 0);
        check("pend_cnt1b", {31'h0, flags_pending}, 32'h1);
        check("pend_status3", {28'h0, status}, 32'hC);
        @(negedge clk);
        drive(0, 1, 1, 0, 0, 0, 32'h8000_0000, 0, 1);
        #1;
`ifdef STATUS_BYPASS_EN
        check("last_commit_fwd", {28'h0, status_fwd}, 32'h3);
        check("last_commit_pending", {31'h0, flags_pending}, 32'h0);
`else
        check("last_commit_fwd", {28'h0, status_fwd}, 32'hC);
        check("last_commit_pending", {31'h0, flags_pending}, 32'h1);
`endif
        @(posedge clk);
        #1;
        check("pend_cnt0", {31'h0, flags_pending}, 32'h0);
        check("pend_status4", {28'h0, status}, 32'h3);
        check("pend_err_clean", {31'h0, pend_err}, 32'h0);

        // Flush with commit and issue in the same cycle.
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        cycle(1, 1, 1, 0, 0, 1, 32'h0, 1, 0);
        check("flush_status", {28'h0, status}, 32'hC);
        check("flush_pending", {31'h0, flags_pending}, 32'h0);
        check("flush_err", {31'h0, pend_err}, 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("flush_pending_hold", {31'h0, flags_pending}, 32'h0);

        // Stall freezes the counter; flush under stall still clears it.
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        cycle(1, 1, 1, 0, 1, 0, 32'h0, 1, 1);
        check("stall_pending", {31'h0, flags_pending}, 32'h1);
        check("stall_status", {28'h0, status}, 32'h0);
        cycle(0, 0, 0, 0, 1, 1, 32'h0, 0, 0);
        check("stall_flush_pending", {31'h0, flags_pending}, 32'h0);

        // Underflow: commit with nothing pending.
        do_reset();
        cycle(0, 1, 1, 0, 0, 0, 32'h0000_0005, 0, 0);
        check("underflow_err", {31'h0, pend_err}, 32'h1);
        check("underflow_pending", {31'h0, flags_pending}, 32'h0);
        check("underflow_status", {28'h0, status}, 32'h0);

        // Overflow: four issues with PEND_W=2, then async reset mid-run.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("sat3_err", {31'h0, pend_err}, 32'h0);
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("overflow_err", {31'h0, pend_err}, 32'h1);
        check("overflow_pending", {31'h0, flags_pending}, 32'h1);
        cycle(0, 1, 1, 0, 0, 0, 32'h0, 0, 1);
        check("err_sticky", {31'h0, pend_err}, 32'h1);
        check("err_status", {28'h0, status}, 32'hA);
        cycle(0, 1, 1, 1, 0, 0, 32'h0, 0, 0);
        check("sat_cnt1", {31'h0, flags_pending}, 32'h1);
        cycle(0, 1, 1, 1, 0, 0, 32'h0, 0, 0);
        check("sat_cnt0", {31'h0, flags_pending}, 32'h0);
        check("logic_keeps_v", {28'h0, status}, 32'hA);
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("pre_reset_pending", {31'h0, flags_pending}, 32'h1);
        @(negedge clk);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_status", {28'h0, status}, 32'h0);
        check("async_fwd", {28'h0, status_fwd}, 32'h0);
        check("async_pending", {31'h0, flags_pending}, 32'h0);
        check("async_err", {31'h0, pend_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
